// File: rtl/fm_vtiming_if.sv
// Pixel hand-off between the upstream line FIFO (master) and fm_vtiming (slave).
// A pixel is consumed on every clock where pix_ready and pix_valid are both high.
interface fm_vtiming_if;
  logic       pix_valid;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       pix_ready;

  modport master (output pix_valid, pix_r, pix_g, pix_b, input pix_ready);
  modport slave  (input pix_valid, pix_r, pix_g, pix_b, output pix_ready);
endinterface

// File: rtl/fm_vtiming.sv
// fm_vtiming: raster timing generator and pixel launcher (hsync/vsync/de + RGB) ahead of fm_hdmi.
// Define FM_VTIMING_COLORBAR_EN to add the i_pattern input and an 8-bar colour test pattern.
module fm_vtiming #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk_v,
  input  logic        rst_x,
  input  logic        i_en,
`ifdef FM_VTIMING_COLORBAR_EN
  input  logic        i_pattern,
`endif
  fm_vtiming_if.slave pix,
  output logic        o_vsync,
  output logic        o_hsync,
  output logic        o_de,
  output logic [7:0]  o_cr,
  output logic [7:0]  o_cg,
  output logic [7:0]  o_cb,
  output logic        o_frame_start,
  output logic        o_underflow,
  input  logic        i_clr_underflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        run;
  logic        active;
  logic        line_end;
  logic        frame_end;
  logic        hs_on;
  logic        vs_on;
  logic        fifo_src;
  logic [23:0] rgb_next;

  assign run       = (state == ST_RUN);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign hs_on     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef FM_VTIMING_COLORBAR_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic        pattern;
  logic [2:0]  bar;
  logic [23:0] bar_rgb;

  // Bar index saturates at 7 so the last bar absorbs any remainder pixels.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (h_cnt >= 12'(k * BAR_W)) bar = 3'(k);
    bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  end

  // Pattern selection only changes when a frame (re)starts at h=0, v=0.
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x)                      pattern <= 1'b0;
    else if ((!run && i_en) || (run && frame_end)) pattern <= i_pattern;
  end

  assign fifo_src = !pattern;
`else
  assign fifo_src = 1'b1;
`endif

  // The pop strobe is combinational so the FIFO sees it in the same clock the pixel is sampled.
  assign pix.pix_ready = run && active && fifo_src;

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    rgb_next = 24'h0;
    if (pix.pix_ready && pix.pix_valid) rgb_next = {pix.pix_r, pix.pix_g, pix.pix_b};
`ifdef FM_VTIMING_COLORBAR_EN
    if (run && active && pattern) rgb_next = bar_rgb;
`endif
  end

  // Counters rest at 0 in IDLE so the first RUN clock is the first active pixel.
  always_ff @(posedge clk_v or negedge rst_x) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_x) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
      if (i_en) state <= ST_RUN;
    end else begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
      if (frame_end && !i_en) state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      o_de                 <= 1'b0;
      o_hsync              <= ~HS_POL;
      o_vsync              <= ~VS_POL;
      o_frame_start        <= 1'b0;
      {o_cr, o_cg, o_cb}   <= 24'h0;
      o_underflow          <= 1'b0;
    end else begin
      o_de                 <= run && active;
      o_hsync              <= (run && hs_on) ? HS_POL : ~HS_POL;
      o_vsync              <= (run && vs_on) ? VS_POL : ~VS_POL;
      o_frame_start        <= run && (h_cnt == 12'd0) && (v_cnt == 12'd0);
      {o_cr, o_cg, o_cb}   <= rgb_next;
      if (i_clr_underflow)                        o_underflow <= 1'b0;
      else if (pix.pix_ready && !pix.pix_valid)   o_underflow <= 1'b1;
    end
  end

endmodule
